// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the expansion-RAM bus cycle sequencer.
package ram_ctrl_pkg;

    localparam int WAIT_STATES_MAX = 15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        ACCESS   = 3'd2,
        ACK      = 3'd3,
        WAIT_END = 3'd4
    } ram_state_t;

    // Wait counter width; at least one bit so a zero-wait build still has a counter.
    function automatic int ram_ctr_width(input int wait_states);
        return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
    endfunction

endpackage

// File: rtl/ram_cycle_ctrl.sv
// Sequences 68000 bus cycles that hit expansion RAM into SRAM chip-enable,
// output-enable and byte write-enable strobes with a programmable wait.
module ram_cycle_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic cpu_clk,
    input  logic cpu_reset,
    input  logic cpu_nas,
    input  logic cpu_nuds,
    input  logic cpu_nlds,
    input  logic cpu_rnw,
    input  logic ramce,
    input  logic ramce2,
    input  logic ram_enable,
    output logic sram_nce1,
    output logic sram_nce2,
    output logic sram_noe,
    output logic sram_nwe_u,
    output logic sram_nwe_l,
    output logic ram_d_oe,
    output logic ram_busy,
    output logic ram_ack
);

    localparam int                CTR_W    = ram_ctr_width(WAIT_STATES);
    localparam logic [CTR_W-1:0]  CTR_LOAD = CTR_W'(WAIT_STATES);

    ram_state_t       state;
    logic             nas_z;
    logic             sel2;
    logic             rnw;
    logic [CTR_W-1:0] counter;
    logic             cycle_start;
    logic             active;
    logic             strobe_phase;

    assign cycle_start = nas_z & ~cpu_nas;

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state   <= IDLE;
            nas_z   <= 1'b1;
            sel2    <= 1'b0;
            rnw     <= 1'b0;
            counter <= '0;
        end else begin
            nas_z <= cpu_nas;
            case (state)
                IDLE: begin
                    if (cycle_start && ram_enable && (ramce || ramce2)) begin
                        sel2    <= ramce2;
                        rnw     <= cpu_rnw;
                        counter <= CTR_LOAD;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    state <= cpu_nas ? IDLE : ACCESS;
                end
                ACCESS: begin
                    if (cpu_nas) begin
                        state <= IDLE;
                    end else if (counter != '0) begin
                        counter <= counter - 1'b1;
                    end else begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    state <= cpu_nas ? IDLE : WAIT_END;
                end
                WAIT_END: begin
                    if (cpu_nas) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write strobes follow the live CPU data strobes, so a late /UDS or /LDS
    // still lands inside the access; everything that drives a bus dies with /AS.
    // NOTE: every output is assigned unconditionally in this block, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        active       = (state != IDLE);
        strobe_phase = (state == ACCESS) || (state == ACK) || (state == WAIT_END);
        sram_nce1    = ~(active & ~sel2);
        sram_nce2    = ~(active & sel2);
        sram_noe     = ~(active & rnw & ~cpu_nas);
        ram_d_oe     = active & rnw & ~cpu_nas;
        sram_nwe_u   = ~(strobe_phase & ~rnw & ~cpu_nuds & ~cpu_nas);
        sram_nwe_l   = ~(strobe_phase & ~rnw & ~cpu_nlds & ~cpu_nas);
        ram_busy     = active;
        ram_ack      = (state == ACK);
    end

endmodule

// File: doc/ram_cycle_ctrl.md
# ram_cycle_ctrl

Downstream stage of the expansion-RAM address decode and autoconfig logic. It consumes the 2 MB chip-select decodes and the autoconfig-complete flag. It sequences each 68000 bus cycle that hits expansion RAM into SRAM chip-enable, output-enable and byte write-enable strobes, with a programmable access wait. It signals completion to the bus termination logic and gates the CPU-side data-bus driver.

## Interface
- WAIT_STATES, default 1: extra cpu_clk cycles spent in ACCESS; legal 0..15.
- cpu_clk  in  1  CPU clock; all state changes on rising edge.
- cpu_reset  in  1  asynchronous, active-high reset.
- cpu_nas  in  1  68000 /AS, active low.
- cpu_nuds, cpu_nlds  in  1 each  68000 data strobes, active low.
- cpu_rnw  in  1  68000 R/W (1 = read).
- ramce, ramce2  in  1 each  decoded select for lower / upper 2 MB SRAM; never both high.
- ram_enable  in  1  high once autoconfig is finished; RAM ignores the bus while low.
- sram_nce1, sram_nce2  out  1 each  SRAM chip enables, active low.
- sram_noe  out  1  SRAM output enable, active low.
- sram_nwe_u, sram_nwe_l  out  1 each  SRAM byte write enables, upper/lower, active low.
- ram_d_oe  out  1  enable CPU-side data buffer toward CPU (reads only).
- ram_busy  out  1  high whenever state ≠ IDLE.
- ram_ack  out  1  one-cycle pulse: access complete, bus may be terminated.

## Operation
- Reset values:
  - all active-low outputs = 1;
  - ram_d_oe = ram_ack = ram_busy = 0;
  - state = IDLE;
  - counter = 0.
- Registered copy nas_z = cpu_nas each edge. A cycle start is nas_z==1 && cpu_nas==0.
- IDLE:
  - On cycle start with ram_enable && (ramce | ramce2), latch sel2 = ramce2 and rnw = cpu_rnw, load counter = WAIT_STATES, then go to SETUP.
  - Otherwise stay in IDLE.
- SETUP (1 cycle):
  - Selected nce is low.
  - If rnw: sram_noe low and ram_d_oe high.
  - Go to ACCESS.
- ACCESS:
  - nce and, for reads, noe/d_oe are held.
  - Writes: sram_nwe_u = cpu_nuds and sram_nwe_l = cpu_nlds, sampled live. This covers 68000 write strobes that lag /AS.
  - While counter ≠ 0: decrement and stay.
  - When counter = 0: go to ACK.
- ACK (1 cycle):
  - ram_ack = 1; strobes held as in ACCESS.
  - Go to WAIT_END.
- WAIT_END:
  - Strobes are held.
  - When cpu_nas sampled high, go to IDLE; all outputs return to their reset values on that edge.
- Abort: if cpu_nas is sampled high in SETUP, ACCESS or ACK, go to IDLE next edge. ram_ack is not issued if ACK was not yet reached.
- Combinational safety gating:
  - sram_noe, sram_nwe_u/l and ram_d_oe are each additionally forced inactive while cpu_nas = 1.
  - This means no write or drive ever outlives /AS.
- A write is never issued to an unselected chip. Only one nce is ever low.
- ram_enable falling mid-cycle does not affect the current cycle. It only blocks new starts.

## Timing
- Let edge k be the edge at which the cycle start is detected.
  - SETUP occupies k..k+1.
  - ACCESS occupies WAIT_STATES+1 cycles.
  - ram_ack is high during the cycle after edge k+2+WAIT_STATES.
- WAIT_STATES = 1: ack at k+3 → 4 clocks from /AS sample to ack.
- WAIT_STATES = 0: ack at k+2.
- Counter width = max(1, clog2(WAIT_STATES+1)). The counter never wraps; it is decremented only while ≠ 0.
- Back-to-back cycles:
  - The minimum /AS-high gap is one sample.
  - The return to IDLE and the next start detect require nas_z = 1, so a new start is detected at the earliest one edge after IDLE is re-entered.
- Reset asserted mid-cycle forces all outputs inactive immediately (asynchronous).

## Structure
- Package ram_ctrl_pkg:
  - state enum {IDLE, SETUP, ACCESS, ACK, WAIT_END};
  - WAIT_STATES_MAX = 15;
  - counter-width function.
- Single module. The wait counter is simple enough to stay inline; no sub-module.
- Output gating is one combinational block fed by registered state, latched sel2 and latched rnw.

## Test plan
- Read, lower chip, WAIT_STATES = 1, ram_enable = 1:
  - /AS falls with ramce = 1, rnw = 1.
  - Required: sram_nce1 = 0 and sram_noe = 0 from k; ram_ack pulses once at k+3; all outputs released one edge after /AS rises.
- Word write, upper chip:
  - cpu_nuds and cpu_nlds fall one clock after /AS.
  - Required: sram_nce2 = 0; sram_nwe_u and sram_nwe_l low only in ACCESS/ACK/WAIT_END while the strobes are low; sram_noe stays 1.
- Byte write, lower byte only:
  - Required: sram_nwe_u stays 1 throughout; sram_nwe_l goes low.
- ram_enable = 0 with ramce = 1:
  - Required: no strobe changes, ram_busy stays 0.
  - Then ram_enable = 1: the next cycle is served normally.
- Abort: /AS rises during ACCESS with WAIT_STATES = 3.
  - Required: nwe/noe inactive in the same cycle (combinational); state IDLE next edge; no ram_ack pulse.
- Async reset asserted in WAIT_END:
  - Required: all outputs at reset values with no clock edge.
  - After deassert, the next /AS is handled from IDLE.
